// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller.
//   state_e     : controller state encoding
//   pc_sel_e    : next-pc source select driven into fetch_pc_gen
//   status_t    : registered busy/done/err flags
//   state_status: maps a state to the status flags it presents
package fetch_pkg;

  localparam int INST_BYTES = 4;
  localparam int COUNT_W    = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_e;

  typedef struct packed {
    logic busy;
    logic done;
    logic err;
  } status_t;

  function automatic status_t state_status(state_e s);
    status_t st;
    st.busy = (s == S_RUN) || (s == S_DRAIN);
    st.done = (s == S_DONE);
    st.err  = (s == S_ERR);
    return st;
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-pc generation for the fetch controller.
//   i_pc          : current pc
//   i_sel         : hold / +4 / redirect
//   i_redirect_pc : branch target
//   o_next_pc     : selected next pc
//   o_target_ok   : redirect target is word aligned and inside the program
//   o_last        : pc+4 reaches ADDR_LIMIT (current fetch is the final one)
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] ADDR_LIMIT = WIDTH'(1024)
) (
  input  logic [WIDTH-1:0] i_pc,
  input  pc_sel_e          i_sel,
  input  logic [WIDTH-1:0] i_redirect_pc,
  output logic [WIDTH-1:0] o_next_pc,
  output logic             o_target_ok,
  output logic             o_last
);

  logic [WIDTH-1:0] w_pc_inc;

  assign w_pc_inc    = i_pc + WIDTH'(INST_BYTES);
  assign o_last      = (w_pc_inc == ADDR_LIMIT);
  assign o_target_ok = (i_redirect_pc[1:0] == 2'b00) && (i_redirect_pc < ADDR_LIMIT);

  always_comb begin
    o_next_pc = i_pc;
    case (i_sel)
      PC_INC:   o_next_pc = w_pc_inc;
      PC_REDIR: o_next_pc = i_redirect_pc;
      default:  o_next_pc = i_pc;
    endcase
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the pc, reads the combinational
// instruction memory and offers one instruction at a time to decode over a
// valid/ready handshake. Handles stall, branch redirect, end of program and
// bad redirect targets.
//   clk, rst                 : clock, async active-high reset
//   start                    : begin fetching at RESET_PC (IDLE/DONE/ERR only)
//   imem_addr / imem_data    : memory address (= pc) and read word
//   inst_valid/ready/data/pc : output slot to decode
//   redirect_valid/pc        : taken branch and its target
//   busy / done / err        : RUN-or-DRAIN / DONE / ERR
//   fetch_count              : handshakes since start, saturating
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] ADDR_LIMIT = WIDTH'(1024)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   imem_addr,
  input  logic [WIDTH-1:0]   imem_data,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [WIDTH-1:0]   inst_data,
  output logic [WIDTH-1:0]   inst_pc,
  input  logic               redirect_valid,
  input  logic [WIDTH-1:0]   redirect_pc,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [COUNT_W-1:0] fetch_count
);

  state_e             r_state;
  status_t            r_status;
  logic [WIDTH-1:0]   r_pc;
  logic               r_inst_valid;
  logic [WIDTH-1:0]   r_inst_data;
  logic [WIDTH-1:0]   r_inst_pc;
  logic [COUNT_W-1:0] r_fetch_count;

  logic             w_accept;
  logic             w_slot_free;
  logic             w_active;
  logic             w_target_ok;
  logic             w_last;
  logic [WIDTH-1:0] w_next_pc;
  pc_sel_e          w_pc_sel;

  assign w_accept    = r_inst_valid & inst_ready;
  assign w_slot_free = ~r_inst_valid | inst_ready;
  assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);

  // Redirect outranks both fetch and stall; DRAIN never advances the pc.
  always_comb begin
    w_pc_sel = PC_HOLD;
    if (w_active && redirect_valid) begin
      if (w_target_ok) w_pc_sel = PC_REDIR;
    end else if (r_state == S_RUN && w_slot_free) begin
      w_pc_sel = PC_INC;
    end
  end

  fetch_pc_gen #(
    .WIDTH      (WIDTH),
    .ADDR_LIMIT (ADDR_LIMIT)
  ) u_pc_gen (
    .i_pc          (r_pc),
    .i_sel         (w_pc_sel),
    .i_redirect_pc (redirect_pc),
    .o_next_pc     (w_next_pc),
    .o_target_ok   (w_target_ok),
    .o_last        (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_status      <= '0;
      r_pc          <= RESET_PC;
      r_inst_valid  <= 1'b0;
      r_inst_data   <= '0;
      r_inst_pc     <= '0;
      r_fetch_count <= '0;
    end else begin
      // Handshake counting is state independent; start below overrides it.
      if (w_accept && (r_fetch_count != '1))
        r_fetch_count <= r_fetch_count + COUNT_W'(1);

      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_pc          <= RESET_PC;
            r_inst_valid  <= 1'b0;
            r_fetch_count <= '0;
            if (RESET_PC >= ADDR_LIMIT) begin
              r_state  <= S_DONE;
              r_status <= state_status(S_DONE);
            end else begin
              r_state  <= S_RUN;
              r_status <= state_status(S_RUN);
            end
          end
        end

        S_RUN, S_DRAIN: begin
          if (redirect_valid) begin
            // Flush the held instruction; an accept this same cycle is
            // already counted above.
            r_inst_valid <= 1'b0;
            if (w_target_ok) begin
              r_pc     <= w_next_pc;
              r_state  <= S_RUN;
              r_status <= state_status(S_RUN);
            end else begin
              r_state  <= S_ERR;
              r_status <= state_status(S_ERR);
            end
          end else if (r_state == S_RUN) begin
            if (w_slot_free) begin
              r_inst_data  <= imem_data;
              r_inst_pc    <= r_pc;
              r_inst_valid <= 1'b1;
              r_pc         <= w_next_pc;
              if (w_last) begin
                r_state  <= S_DRAIN;
                r_status <= state_status(S_DRAIN);
              end
            end
          end else if (w_accept) begin
            r_inst_valid <= 1'b0;
            r_state      <= S_DONE;
            r_status     <= state_status(S_DONE);
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_status <= state_status(S_IDLE);
        end
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign inst_valid  = r_inst_valid;
  assign inst_data   = r_inst_data;
  assign inst_pc     = r_inst_pc;
  assign busy        = r_status.busy;
  assign done        = r_status.done;
  assign err         = r_status.err;
  assign fetch_count = r_fetch_count;

endmodule
